// File: rtl/muldiv_pkg.sv
// Shared op encodings, FSM state constants and op classification for the muldiv unit.
// The MADD/MSUB family is recognised only when MULDIV_MADD_EN is defined.
package muldiv_pkg;

  localparam logic [3:0] OP_MULT  = 4'd0;
  localparam logic [3:0] OP_MULTU = 4'd1;
  localparam logic [3:0] OP_DIV   = 4'd2;
  localparam logic [3:0] OP_DIVU  = 4'd3;
  localparam logic [3:0] OP_MTHI  = 4'd4;
  localparam logic [3:0] OP_MTLO  = 4'd5;
  localparam logic [3:0] OP_MADD  = 4'd6;
  localparam logic [3:0] OP_MADDU = 4'd7;
  localparam logic [3:0] OP_MSUB  = 4'd8;
  localparam logic [3:0] OP_MSUBU = 4'd9;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  // True for ops that occupy the unit for several cycles; the stall controller reuses this.
  function automatic logic is_muldiv_op(input logic [3:0] op);
    logic hit;
    hit = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`ifdef MULDIV_MADD_EN
    hit = hit || (op == OP_MADD) || (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
`endif
    return hit;
  endfunction

  function automatic logic is_mul_class(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_MADD) ||
           (op == OP_MADDU) || (op == OP_MSUB) || (op == OP_MSUBU);
  endfunction

endpackage

// File: rtl/muldiv_calc.sv
// Combinational result generator: products, quotients and the divide special cases.
// Accumulate ops exist only when MULDIV_MADD_EN is defined; otherwise they pass acc through.
module muldiv_calc
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [3:0]         op,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [2*WIDTH-1:0] acc,
  output logic [2*WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] ONE      = {{(WIDTH-1){1'b0}}, 1'b1};

  logic                 signed_op;
  logic                 neg_a;
  logic                 neg_b;
  logic [2*WIDTH-1:0]   ext_a;
  logic [2*WIDTH-1:0]   ext_b;
  logic [2*WIDTH-1:0]   product;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;
  logic [WIDTH-1:0]     div_b;
  logic [WIDTH-1:0]     quo_mag;
  logic [WIDTH-1:0]     rem_mag;
  logic [WIDTH-1:0]     quo;
  logic [WIDTH-1:0]     rem;
  logic                 div_zero;
  logic                 div_ovf;

  // Sign-extended operands give the correct signed product modulo 2^(2*WIDTH).
  always_comb begin
    signed_op = (op == OP_MULT) || (op == OP_DIV) || (op == OP_MADD) || (op == OP_MSUB);
    neg_a     = signed_op & a[WIDTH-1];
    neg_b     = signed_op & b[WIDTH-1];
    ext_a     = signed_op ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
    ext_b     = signed_op ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
    product   = ext_a * ext_b;
  end

  // Divide on magnitudes, then restore signs: quotient truncates, remainder follows the dividend.
  always_comb begin
    mag_a    = neg_a ? -a : a;
    mag_b    = neg_b ? -b : b;
    div_b    = (mag_b == '0) ? ONE : mag_b;
    quo_mag  = mag_a / div_b;
    rem_mag  = mag_a % div_b;
    quo      = (neg_a ^ neg_b) ? -quo_mag : quo_mag;
    rem      = neg_a ? -rem_mag : rem_mag;
    div_zero = (b == '0);
    div_ovf  = signed_op && (a == MOST_NEG) && (b == '1);
  end

  always_comb begin
    result = acc;
    case (op)
      OP_MULT, OP_MULTU: result = product;
      OP_DIV, OP_DIVU: begin
        if (div_zero)
          result = {a, {WIDTH{1'b1}}};
        else if (div_ovf)
          result = {{WIDTH{1'b0}}, a};
        else
          result = {rem, quo};
      end
`ifdef MULDIV_MADD_EN
      OP_MADD, OP_MADDU: result = acc + product;
      OP_MSUB, OP_MSUBU: result = acc - product;
`endif
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO registers.
// Define MULDIV_MADD_EN to enable the MADD/MADDU/MSUB/MSUBU accumulate ops.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW         = $clog2(MAX_CYCLES) + 1;
  localparam logic [CW-1:0] MUL_LOAD = CW'(MUL_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD = CW'(DIV_CYCLES - 1);

  logic [0:0]         state;
  logic [CW-1:0]      count;
  logic [3:0]         op_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [2*WIDTH-1:0] result;

  // HI/LO cannot change during RUN, so they double as the accumulator captured at launch.
  muldiv_calc #(
    .WIDTH (WIDTH)
  ) u_calc (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .acc    ({hi, lo}),
    .result (result)
  );

  assign busy = (state == ST_RUN);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_IDLE;
      count <= '0;
      op_q  <= '0;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else if (state == ST_IDLE) begin
      // A flush in the launch cycle squashes the instruction, including MTHI/MTLO.
      if (start && !flush) begin
        if (is_muldiv_op(op)) begin
          op_q  <= op;
          a_q   <= a;
          b_q   <= b;
          count <= is_mul_class(op) ? MUL_LOAD : DIV_LOAD;
          state <= ST_RUN;
        end else if (op == OP_MTHI) begin
          hi <= a;
        end else if (op == OP_MTLO) begin
          lo <= a;
        end
      end
    end else begin
      if (flush) begin
        state <= ST_IDLE;
      end else if (count == '0) begin
        hi    <= result[2*WIDTH-1:WIDTH];
        lo    <= result[WIDTH-1:0];
        state <= ST_IDLE;
      end else begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomised self-checking bench for muldiv_unit against a plain-arithmetic HI/LO model.
// Compile with MULDIV_MADD_EN defined to also exercise the accumulate ops.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic [3:0]   op = '0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         flush = 1'b0;
  logic         busy;
  logic [W-1:0] hi;
  logic [W-1:0] lo;

  int total = 0;
  int bad = 0;
  logic [63:0] model = '0;

  muldiv_unit #(
    .WIDTH      (W),
    .MUL_CYCLES (MUL_N),
    .DIV_CYCLES (DIV_N)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .op    (op),
    .a     (a),
    .b     (b),
    .flush (flush),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  // The stall controller should never let this happen; the unit must ignore it.
  always @(posedge clk) begin
    if (reset && busy && start)
      $display("[TB] note: start raised while busy, expecting it to be ignored");
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic refLaunches(input logic [3:0] o);
`ifdef MULDIV_MADD_EN
    return o <= 4'd3 || (o >= 4'd6 && o <= 4'd9);
`else
    return o <= 4'd3;
`endif
  endfunction

  function automatic int refLatency(input logic [3:0] o);
    return (o == OP_DIV || o == OP_DIVU) ? DIV_N : MUL_N;
  endfunction

  function automatic logic [63:0] refResult(input logic [3:0] o, input logic [31:0] x,
                                            input logic [31:0] y, input logic [63:0] acc);
    longint      sp;
    logic [63:0] ux, uy, up;
    int          sx, sy, q, r;
    sp = longint'(signed'(x)) * longint'(signed'(y));
    ux = {32'd0, x};
    uy = {32'd0, y};
    up = ux * uy;
    case (o)
      OP_MULT:  return sp;
      OP_MULTU: return up;
      OP_DIV, OP_DIVU: begin
        if (y == 0) return {x, 32'hFFFF_FFFF};
        if (o == OP_DIVU) return {x % y, x / y};
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'd0, x};
        sx = signed'(x);
        sy = signed'(y);
        q = sx / sy;
        r = sx % sy;
        return {r, q};
      end
      OP_MTHI: return {x, acc[31:0]};
      OP_MTLO: return {acc[63:32], x};
`ifdef MULDIV_MADD_EN
      OP_MADD:  return acc + sp;
      OP_MADDU: return acc + up;
      OP_MSUB:  return acc - sp;
      OP_MSUBU: return acc - up;
`endif
      default: return acc;
    endcase
  endfunction

  // One full instruction: launch, latency count, HI/LO hold and final result.
  task automatic applyStimulus(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y);
    int n;
    @(negedge clk);
    start = 1'b1;
    op = o;
    a = x;
    b = y;
    @(negedge clk);
    start = 1'b0;
    a = $urandom;
    b = $urandom;
    if (refLaunches(o)) begin
      checkOutput($sformatf("busy_launch_op%0d", o), {63'd0, busy}, 64'd1);
      checkOutput($sformatf("hold_run_op%0d", o), {hi, lo}, model);
      n = 0;
      while (busy && n < 60) begin
        n++;
        @(negedge clk);
      end
      checkOutput($sformatf("latency_op%0d", o), 64'(n), 64'(refLatency(o)));
    end else begin
      checkOutput($sformatf("busy_idle_op%0d", o), {63'd0, busy}, 64'd0);
    end
    model = refResult(o, x, y, model);
    checkOutput($sformatf("hilo_op%0d", o), {hi, lo}, model);
  endtask

  initial begin
    logic [3:0]  ro;
    logic [31:0] ra, rb;
    int n;

    repeat (2) @(negedge clk);
    checkOutput("reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    checkOutput("plan_mult", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFEB);
    applyStimulus(OP_DIVU, 32'd100, 32'd7);
    checkOutput("plan_divu", {hi, lo}, {32'd2, 32'd14});
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    checkOutput("plan_div_neg", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    checkOutput("plan_div_ovf", {hi, lo}, {32'd0, 32'h8000_0000});
    applyStimulus(OP_DIVU, 32'd5, 32'd0);
    checkOutput("plan_div_zero", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    applyStimulus(OP_MTLO, 32'h1234, 32'd0);
    checkOutput("plan_mtlo", {32'd0, lo}, 64'h1234);

    // Flush on the third busy cycle.
    @(negedge clk);
    start = 1'b1; op = OP_MULT; a = 32'd9; b = 32'd9;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checkOutput("flush_busy", {63'd0, busy}, 64'd0);
    repeat (8) @(negedge clk);
    checkOutput("flush_hilo", {hi, lo}, model);

    // Start together with flush launches nothing and writes nothing.
    start = 1'b1; flush = 1'b1; op = OP_MULT; a = 32'd3; b = 32'd3;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("startflush_busy", {63'd0, busy}, 64'd0);
    start = 1'b1; flush = 1'b1; op = OP_MTLO; a = 32'hDEAD;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    checkOutput("startflush_mtlo", {hi, lo}, model);

    // Start during RUN is ignored.
    start = 1'b1; op = OP_DIVU; a = 32'd100; b = 32'd7;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (busy && n < 60) begin
      n++;
      if (n == 3) begin
        start = 1'b1; op = OP_MULT; a = 32'd2; b = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
    checkOutput("run_start_latency", 64'(n), 64'(DIV_N));
    model = {32'd2, 32'd14};
    checkOutput("run_start_hilo", {hi, lo}, model);

    // Asynchronous reset in the middle of RUN.
    start = 1'b1; op = OP_MULT; a = 32'd5; b = 32'd5;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    checkOutput("midrun_reset_busy", {63'd0, busy}, 64'd0);
    checkOutput("midrun_reset_hilo", {hi, lo}, 64'd0);
    model = '0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

`ifdef MULDIV_MADD_EN
    applyStimulus(OP_MTHI, 32'd0, 32'd0);
    applyStimulus(OP_MTLO, 32'd10, 32'd0);
    applyStimulus(OP_MADD, 32'd3, 32'd4);
    checkOutput("plan_madd", {hi, lo}, 64'd22);
`else
    applyStimulus(OP_MTLO, 32'd10, 32'd0);
    applyStimulus(OP_MADD, 32'd3, 32'd4);
    checkOutput("madd_disabled", {hi, lo}, 64'd10);
`endif

    for (int i = 0; i < 40; i++) begin
      ro = 4'($urandom_range(0, 11));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: begin ra = $urandom_range(0, 200) - 100; rb = $urandom_range(0, 20) - 10; end
        default: ;
      endcase
      applyStimulus(ro, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit with architectural HI/LO registers.
- Sits in the EX stage beside the ALU and drives the `busy` input of the stall controller.
- Successor to the fixed-width muldiv path:
  - configurable width and per-class latency;
  - signed and unsigned operations;
  - in-flight cancel (`flush`);
  - defined divide-by-zero and overflow results;
  - optional multiply-accumulate.

Parameters:
- WIDTH, 32, operand and HI/LO width in bits (>=8).
- MUL_CYCLES, 5, busy cycles for multiply-class ops (>=1).
- DIV_CYCLES, 10, busy cycles for divide-class ops (>=1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-low reset (0 = reset).
- start  input  1  launch request, sampled only when idle; one-cycle pulse from the ID/EX register.
- op  input  4  operation code (encodings in the package).
- a  input  WIDTH  rs operand (forwarded value).
- b  input  WIDTH  rt operand (forwarded value).
- flush  input  1  cancel the in-flight operation (exception/squash).
- busy  output  1  operation in flight; the stall controller holds any ID muldiv instruction while busy|start.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.

Behaviour:
- Reset (reset=0, asynchronous):
  - busy=0, hi=0, lo=0;
  - counter=0, state IDLE;
  - an in-flight operation is discarded.
- States: IDLE, RUN.
- IDLE -> RUN: start=1 and op in {MULT, MULTU, DIV, DIVU} at edge t0.
  - Operands and op are latched.
  - Counter is loaded with MUL_CYCLES-1 or DIV_CYCLES-1.
  - busy=1 after t0.
- RUN: counter decrements each edge. At the edge where counter==0:
  - hi/lo are written;
  - busy=0;
  - state returns to IDLE.
  - busy is therefore high for exactly N cycles; results are visible after edge t0+N.
- MTHI/MTLO with start=1 in IDLE:
  - writes a into hi or lo at t0;
  - busy stays 0 (single cycle).
- start while RUN: ignored. The stall controller must prevent it; the bench flags it as an assertion.
- hi/lo hold their previous values throughout RUN. An MFHI/MFLO issued during RUN is stalled externally.
- Result arithmetic:
  - MULT: signed 2*WIDTH-bit product; hi = upper half, lo = lower half.
  - MULTU: same, unsigned.
  - DIV: signed; lo = quotient truncated toward zero, hi = remainder with the sign of the dividend.
  - DIVU: same, unsigned.
- Divide by zero (b==0): lo = all ones, hi = a; normal latency.
- Signed overflow (a = most-negative, b = -1): lo = a, hi = 0.
- flush=1:
  - In RUN: state -> IDLE and busy=0 next edge; hi/lo unchanged.
  - With start in the same cycle: flush wins, start is ignored, MTHI/MTLO are not written.
- Counter width: clog2 of max(MUL_CYCLES, DIV_CYCLES) + 1.

Optional Feature:
- Macro: MULDIV_MADD_EN.
- Defined: adds MADD, MADDU, MSUB, MSUBU.
  - The 2*WIDTH-bit product (signed or unsigned) is added to / subtracted from the latched {hi,lo} with wrap-around modulo 2^(2*WIDTH).
  - Latency MUL_CYCLES.
  - {hi,lo} is captured at t0.
- Not defined: those op codes are treated as no-ops; busy stays 0 and hi/lo are unchanged.

Decomposition:
- Package muldiv_pkg:
  - 4-bit op encodings: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5, MADD=6, MADDU=7, MSUB=8, MSUBU=9;
  - state enum IDLE/RUN;
  - function is_muldiv_op(op) for reuse by the stall controller.
- Sub-module muldiv_calc: purely combinational result generator.
  - Inputs: latched op, a, b, {hi,lo}.
  - Output: {hi_next, lo_next}.
  - Owns the sign handling and the zero/overflow special cases.
  - The top holds the FSM, counter and registers.

Test Plan:
- MULT a=-3 (0xFFFFFFFD), b=7 -> busy high exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFEB.
- DIVU a=100, b=7 -> busy 10 cycles; then lo=14, hi=2. DIV a=-7, b=2 -> lo=-3 (0xFFFFFFFD), hi=-1.
- DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0. DIVU a=5, b=0 -> lo=0xFFFFFFFF, hi=5.
- MULT in flight; flush on cycle 3 -> busy=0 next cycle; hi/lo retain prior values. Start+flush in the same cycle -> nothing launched.
- MTLO a=0x1234 with busy=0 -> lo=0x1234 next edge, busy never rises. Start pulsed during RUN -> ignored, original result intact.
- Reset pulled low mid-RUN -> busy, hi, lo = 0 immediately. With MULDIV_MADD_EN: hi:lo=0:10, MADD 3*4 -> lo=22.
